// File: rtl/adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Holds the slot state encoding, the debug counter width and the rotating first-set search.
package adder_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int BUSY_CNT_W = 8;

  // One-hot grant over up to 8 requesters.
  // The search starts at ptr and wraps at n; bits at index n and above are never granted.
  function automatic logic [7:0] rr_pick(input logic [7:0] vld,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [7:0] g;
    int         idx;
    g = '0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && g == '0 && vld[idx[2:0]]) g[idx[2:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Plain WIDTH-bit datapath adder shared by the arbiter.
// The carry out is dropped, so the sum wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one adder between NUM_REQ requesters.
// A single registered result slot returns the sum together with the winning requester index.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic [BUSY_CNT_W-1:0]    busy_cnt
);

  state_e                  state_q;
  logic [ID_W-1:0]         rr_q, rr_d, id_q, win_id;
  logic [WIDTH-1:0]        sum_q, op_a, op_b, sum_d;
  logic [BUSY_CNT_W-1:0]   busy_q;
  logic [7:0]              vld8, gnt8;
  logic [2:0]              ptr3;
  logic [NUM_REQ-1:0]      gnt;
  logic                    can_accept, accept, stall;

  // Zero-extend to the fixed 8-wide search used by the package helper.
  always_comb begin
    vld8 = '0;
    vld8[NUM_REQ-1:0] = req_valid;
    ptr3 = '0;
    ptr3[ID_W-1:0] = rr_q;
  end

  assign gnt8       = rr_pick(vld8, ptr3, NUM_REQ);
  assign gnt        = gnt8[NUM_REQ-1:0];
  assign can_accept = (state_q == EMPTY) | resp_ready;
  // Gate with reset so nothing is acknowledged while the block is held in reset.
  assign req_ready  = gnt & {NUM_REQ{can_accept & reset_n}};
  assign accept     = |(req_valid & req_ready);
  assign stall      = (|req_valid) & ~(|req_ready);

  always_comb begin
    win_id = '0;
    op_a   = '0;
    op_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_id = ID_W'(i);
        op_a   = req_a[i*WIDTH +: WIDTH];
        op_b   = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_d = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      rr_q    <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      busy_q  <= '0;
    end else begin
      // A new accept wins over a drain, so the slot is simply overwritten.
      if (accept) begin
        state_q <= FULL;
        sum_q   <= sum_d;
        id_q    <= win_id;
        rr_q    <= rr_d;
      end else if (state_q == FULL && resp_ready) begin
        state_q <= EMPTY;
      end
      if (stall && busy_q != '1) busy_q <= busy_q + 1'b1;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign busy_cnt   = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, single add, wrap, round-robin order,
// backpressure with simultaneous drain and accept, counter saturation and async reset.
module tb_adder_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       req_valid, req_ready;
  logic [3:0][31:0] a_arr, b_arr;
  logic             resp_valid, resp_ready;
  logic [1:0]       resp_id;
  logic [31:0]      resp_sum;
  logic [7:0]       busy_cnt;

  int passed = 0;
  int total  = 0;

  adder_arbiter #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (a_arr),
    .req_b      (b_arr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Step past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{0, 1, 2, 3, 0};

    reset_n    = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    a_arr      = '0;
    b_arr      = '0;
    #1;
    repeat (3) tick();
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",  32'(busy_cnt), 32'd0);
    chk("rst_sum",   resp_sum, 32'd0);
    chk("rst_id",    32'(resp_id), 32'd0);

    req_valid = 4'b0000;
    reset_n   = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_valid", 32'(resp_valid), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_busy",  32'(busy_cnt), 32'd0);
    end

    // Single add on requester 2.
    a_arr[2] = 32'h5; b_arr[2] = 32'h7; req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_id",    32'(resp_id), 32'd2);
    chk("single_sum",   resp_sum, 32'hC);

    // Pointer now 3: requester 3 wins over 0, then 0 wraps around the adder.
    a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h2;
    a_arr[3] = 32'h10;        b_arr[3] = 32'h20;
    req_valid = 4'b1001;
    #1 chk("ptr3_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    chk("ptr3_id",  32'(resp_id), 32'd3);
    chk("ptr3_sum", resp_sum, 32'h30);
    #1 chk("wrap_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    chk("wrap_id",    32'(resp_id), 32'd0);
    chk("wrap_sum",   resp_sum, 32'h1);
    chk("wrap_valid", 32'(resp_valid), 32'd1);
    tick();
    chk("drain_valid", 32'(resp_valid), 32'd0);

    // Pointer is 1; one accept on requester 3 brings it back to 0.
    a_arr[3] = 32'h1; b_arr[3] = 32'h1; req_valid = 4'b1000;
    tick();
    chk("pre_rr_sum", resp_sum, 32'h2);

    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 32'h100 * i;
      b_arr[i] = i;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(1) << order[k]);
      tick();
      chk("rr_id",  32'(resp_id), 32'(order[k]));
      chk("rr_sum", resp_sum, 32'h101 * order[k]);
    end

    // Backpressure: slot holds requester 0's result, requester 1 waits.
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    repeat (4) begin
      #1 chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_id",    32'(resp_id), 32'd0);
      chk("bp_sum",   resp_sum, 32'd0);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      tick();
    end
    chk("bp_busy", 32'(busy_cnt), 32'd4);
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    chk("bp_new_id",  32'(resp_id), 32'd1);
    chk("bp_new_sum", resp_sum, 32'h101);
    chk("bp_new_vld", 32'(resp_valid), 32'd1);
    chk("bp_busy_hold", 32'(busy_cnt), 32'd4);

    // Saturation of the stall counter.
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    repeat (260) tick();
    chk("busy_sat", 32'(busy_cnt), 32'd255);
    chk("sat_valid", 32'(resp_valid), 32'd1);

    // Asynchronous reset between edges while the slot is full.
    #2 reset_n = 1'b0;
    #1 chk("arst_valid", 32'(resp_valid), 32'd0);
    chk("arst_busy",  32'(busy_cnt), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    tick();
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    #1 chk("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    chk("post_rst_id",  32'(resp_id), 32'd0);
    chk("post_rst_sum", resp_sum, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
